align_shift_unit: RTL

- Pre-add alignment stage of the floating point adder; the counterpart of the post-add normalization shift detector.
- Compares two operand exponents and swaps operands so the larger-magnitude operand is "big".
- Right-shifts the smaller mantissa by the exponent difference, extended with guard, round and sticky bits.
- Multi-cycle iterative shifter with valid/ready handshakes on both sides.

---
 rtl/align_shift_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/align_shift_unit.sv
// align_shift_unit: pre-add alignment stage of the floating point adder.
// Orders the operand pair so the larger magnitude is "big", then right-shifts
// the small mantissa by the clamped exponent difference. The shift runs over
// several cycles, at most STEP positions per cycle. Guard, round and sticky
// bits are carried below the mantissa as {mantissa,G,R,S}.
// Optional feature macro: ALIGN_ZERO_BYPASS_EN. When it is defined, a zero
// small mantissa skips the SHIFT phase entirely.
module align_shift_unit #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  parameter int STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   ea,
  input  logic [EXP_W-1:0]   eb,
  input  logic [WIDTH-1:0]   ma,
  input  logic [WIDTH-1:0]   mb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_out,
  output logic [WIDTH-1:0]   m_big,
  output logic [WIDTH+2:0]   m_small,
  output logic [4:0]         sh,
  output logic               swap
);

  localparam int MW = WIDTH + 3;  // working width {mantissa,G,R,S}
  localparam logic [EXP_W:0] MW_E   = (EXP_W+1)'(MW);
  localparam logic [4:0]     MW_S   = 5'(MW);
  localparam logic [4:0]     STEP_V = 5'(STEP);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [EXP_W-1:0]   ea_q, eb_q;
  logic [WIDTH-1:0]   ma_q, mb_q;
  logic [4:0]         rem;
  logic [MW-1:0]      w;

  // Compare-phase decode, from the captured operand pair.
  logic               cmp_swap;
  logic [EXP_W:0]     d_full;
  logic [4:0]         d_clamp;
  logic [WIDTH-1:0]   small_sel;
  logic               bypass;

  // Shift-phase decode.
  logic [4:0]         k;
  logic [MW-1:0]      lost_mask;
  logic               lost;
  logic [MW-1:0]      w_next;

  assign cmp_swap  = (eb_q > ea_q) || ((eb_q == ea_q) && (mb_q > ma_q));
  // The extra top bit keeps the difference free of wrap-around.
  assign d_full    = cmp_swap ? ({1'b0, eb_q} - {1'b0, ea_q})
                              : ({1'b0, ea_q} - {1'b0, eb_q});
  assign d_clamp   = (d_full > MW_E) ? MW_S : d_full[4:0];
  assign small_sel = cmp_swap ? ma_q : mb_q;

`ifdef ALIGN_ZERO_BYPASS_EN
  assign bypass = (small_sel == '0);
`else
  assign bypass = 1'b0;
`endif

  // k never exceeds MW, so a shift of the whole register gives zero rather
  // than wrapping. The 32-bit mask stays exact because MW is at most 31.
  assign k         = (rem > STEP_V) ? STEP_V : rem;
  assign lost_mask = MW'((32'd1 << k) - 32'd1);
  assign lost      = |(w & lost_mask);
  assign w_next    = (w >> k) | {{(MW-1){1'b0}}, lost};

  // State register.
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples values from before the edge, whatever order the processes run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and handshake readiness.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CMP;
      end
      CMP: begin
        if (d_clamp == 5'd0 || bypass) state_next = DONE;
        else                            state_next = SHIFT;
      end
      SHIFT: begin
        if (rem <= STEP_V) state_next = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, compare/load, iterative shift, result publish.
  // NOTE: the capture and work registers are reset along with the outputs.
  // They are only a few flops, and a reset that leaves nothing stale makes an
  // aborted operation easy to reason about.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      rem       <= '0;
      w         <= '0;
      out_valid <= 1'b0;
      exp_out   <= '0;
      m_big     <= '0;
      m_small   <= '0;
      sh        <= '0;
      swap      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ea_q <= ea;
            eb_q <= eb;
            ma_q <= ma;
            mb_q <= mb;
          end
        end
        CMP: begin
          swap    <= cmp_swap;
          exp_out <= cmp_swap ? eb_q : ea_q;
          m_big   <= cmp_swap ? mb_q : ma_q;
          sh      <= d_clamp;
          rem     <= d_clamp;
          w       <= bypass ? '0 : {small_sel, 3'b000};
        end
        SHIFT: begin
          w   <= w_next;
          rem <= rem - k;
        end
        DONE: begin
          // The first DONE cycle publishes the result. After that the
          // outputs hold until downstream takes them.
          if (!out_valid) begin
            out_valid <= 1'b1;
            m_small   <= w;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
